instr_fetch_queue: RTL and testbench

Parametrised instruction fetch stage. It replaces the combinational PC-to-instruction lookup with an owned fetch PC, a synchronous-read instruction ROM, and a small prefetch queue. Instructions are delivered to decode over a valid/ready handshake. Branch/jump redirects flush all prefetched work. The block sits between the control unit's PC-redirect logic and the decode stage.

---
 rtl/instr_fetch_queue_pkg.sv | 21 ++
 rtl/instr_fetch_queue_fetch_queue.sv | 69 ++++++
 rtl/instr_fetch_queue.sv | 106 ++++++++++
 tb/tb_instr_fetch_queue.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_queue_pkg.sv
// Shared constants and elaboration helpers for the instruction fetch stage.
package instr_fetch_queue_pkg;

  localparam int unsigned NOP_MAX_W = 64;
  localparam logic [NOP_MAX_W-1:0] NOP_ENCODING = '0;

  function automatic int unsigned instr_bytes(input int unsigned instr_w);
    return instr_w / 8;
  endfunction

  // Ceiling log2; returns 0 for an argument of 0 or 1.
  function automatic int unsigned clog2_u(input int unsigned value);
    int unsigned width;
    width = 0;
    for (int unsigned w = 0; w < 32; w++) begin
      if ((33'd1 << w) < 33'(value)) width = w + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/instr_fetch_queue_fetch_queue.sv
// Show-ahead synchronous FIFO holding prefetched {fault, pc, instr} entries.
module fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        push,
  input  logic [INSTR_W-1:0]          push_instr,
  input  logic [ADDR_W-1:0]           push_pc,
  input  logic                        push_fault,
  input  logic                        pop,
  output logic [clog2_u(DEPTH):0]     count,
  output logic                        head_valid,
  output logic [INSTR_W-1:0]          head_instr,
  output logic [ADDR_W-1:0]           head_pc,
  output logic                        head_fault
);

  localparam int unsigned PW = clog2_u(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic               fault_mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          pop_en;

  always_comb begin
    pop_en = pop && (cnt != '0);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_en) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop_en);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= push_instr;
      pc_mem[wr_ptr]    <= push_pc;
      fault_mem[wr_ptr] <= push_fault;
    end
  end

  // Head fields read as zero while empty so reset leaves a clean output bus.
  always_comb begin
    head_valid = (cnt != '0);
    head_instr = head_valid ? instr_mem[rd_ptr] : '0;
    head_pc    = head_valid ? pc_mem[rd_ptr]    : '0;
    head_fault = head_valid ? fault_mem[rd_ptr] : 1'b0;
    count      = cnt;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owned fetch PC, registered-read instruction ROM and a prefetch
// queue delivering instructions to decode over valid/ready.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       INSTR_W     = 16,
  parameter int unsigned       DEPTH_WORDS = 128,
  parameter int unsigned       QUEUE_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter string             INIT_FILE   = ""
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Redirect,
  input  logic [ADDR_W-1:0]  RedirectPC,
  input  logic               InstrReady,
  output logic               InstrValid,
  output logic [INSTR_W-1:0] Instruction,
  output logic [ADDR_W-1:0]  InstrPC,
  output logic               InstrFault,
  output logic [ADDR_W-1:0]  FetchPC
);

  localparam int unsigned BYTES  = instr_bytes(INSTR_W);
  localparam int unsigned SH     = clog2_u(BYTES);
  localparam int unsigned ROM_AW = (DEPTH_WORDS > 1) ? clog2_u(DEPTH_WORDS) : 1;
  localparam int unsigned CW     = clog2_u(QUEUE_DEPTH) + 1;

  logic [INSTR_W-1:0] rom [DEPTH_WORDS] = '{default: '0};

  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  word_idx;
  logic [ADDR_W-1:0]  align_mask;
  logic [ADDR_W-1:0]  redirect_aligned;
  logic [ROM_AW-1:0]  rom_addr;
  logic               in_range;
  logic               issue;
  logic               push;
  logic               inflight;
  logic [ADDR_W-1:0]  inflight_pc;
  logic               inflight_fault;
  logic [INSTR_W-1:0] rom_q;
  logic [INSTR_W-1:0] push_instr;
  logic [CW-1:0]      count;

  // Issue is throttled on queued plus in-flight so the push a cycle later
  // always finds a free slot.
  always_comb begin
    word_idx         = fetch_pc >> SH;
    in_range         = word_idx < ADDR_W'(DEPTH_WORDS);
    rom_addr         = word_idx[ROM_AW-1:0];
    align_mask       = {ADDR_W{1'b1}} << SH;
    redirect_aligned = RedirectPC & align_mask;
    issue            = !Redirect &&
                       (({1'b0, count} + (CW+1)'(inflight)) < (CW+1)'(QUEUE_DEPTH));
    push             = inflight && !Redirect;
    push_instr       = inflight_fault ? NOP_ENCODING[INSTR_W-1:0] : rom_q;
  end

  always_ff @(posedge Clock) begin
    if (issue && in_range) rom_q <= rom[rom_addr];
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      fetch_pc       <= RESET_PC;
      inflight       <= 1'b0;
      inflight_pc    <= '0;
      inflight_fault <= 1'b0;
    end else if (Redirect) begin
      fetch_pc <= redirect_aligned;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc       <= fetch_pc + ADDR_W'(BYTES);
        inflight_pc    <= fetch_pc;
        inflight_fault <= !in_range;
      end
    end
  end

  fetch_queue #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .DEPTH   (QUEUE_DEPTH)
  ) u_queue (
    .clk        (Clock),
    .rst        (Reset),
    .flush      (Redirect),
    .push       (push),
    .push_instr (push_instr),
    .push_pc    (inflight_pc),
    .push_fault (inflight_fault),
    .pop        (InstrReady),
    .count      (count),
    .head_valid (InstrValid),
    .head_instr (Instruction),
    .head_pc    (InstrPC),
    .head_fault (InstrFault)
  );

  assign FetchPC = fetch_pc;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: redirect vector table plus
// hand-written reset/backpressure sequences, checked through a PC scoreboard.
module tb_instr_fetch_queue;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Redirect;
  logic [15:0] RedirectPC;
  logic        InstrReady;
  logic        InstrValid;
  logic [15:0] Instruction;
  logic [15:0] InstrPC;
  logic        InstrFault;
  logic [15:0] FetchPC;

  int checks = 0;
  int errors = 0;

  logic [15:0] rom_model [128];
  logic [15:0] sb [$];

  typedef struct {
    logic [15:0] target;
    logic [15:0] first_pc;
    int          n;
    logic        rdy;
  } redir_vec_t;

  redir_vec_t vecs [5];

  instr_fetch_queue #(
    .ADDR_W      (16),
    .INSTR_W     (16),
    .DEPTH_WORDS (128),
    .QUEUE_DEPTH (4),
    .RESET_PC    (16'h0000),
    .INIT_FILE   ("")
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Redirect    (Redirect),
    .RedirectPC  (RedirectPC),
    .InstrReady  (InstrReady),
    .InstrValid  (InstrValid),
    .Instruction (Instruction),
    .InstrPC     (InstrPC),
    .InstrFault  (InstrFault),
    .FetchPC     (FetchPC)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_instr(input logic [15:0] pc);
    logic [14:0] w;
    w = pc[15:1];
    if (w >= 15'd128) return 16'h0000;
    return rom_model[w[6:0]];
  endfunction

  function automatic logic exp_fault(input logic [15:0] pc);
    logic [14:0] w;
    w = pc[15:1];
    return (w >= 15'd128);
  endfunction

  always @(negedge Clock) begin
    logic [15:0] p;
    if (Reset === 1'b0 && InstrValid === 1'b1 && InstrReady === 1'b1 && sb.size() != 0) begin
      p = sb.pop_front();
      chk("deliver_pc", InstrPC, p);
      chk("deliver_instr", Instruction, exp_instr(p));
      chk("deliver_fault", InstrFault, exp_fault(p));
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic expect_seq(input logic [15:0] first, input int n);
    for (int k = 0; k < n; k++) sb.push_back(first + 16'(2 * k));
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 40) begin
      @(negedge Clock);
      k++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s timeout pending=%0d required=0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    vecs[0] = '{target: 16'h000A, first_pc: 16'h000A, n: 2, rdy: 1'b0};
    vecs[1] = '{target: 16'h0013, first_pc: 16'h0012, n: 2, rdy: 1'b1};
    vecs[2] = '{target: 16'h00FE, first_pc: 16'h00FE, n: 2, rdy: 1'b0};
    vecs[3] = '{target: 16'hFFFE, first_pc: 16'hFFFE, n: 2, rdy: 1'b1};
    vecs[4] = '{target: 16'h0007, first_pc: 16'h0006, n: 3, rdy: 1'b0};

    for (int i = 0; i < 128; i++) begin
      if (i < 4) rom_model[i] = 16'h1111 * 16'(i + 1);
      else       rom_model[i] = 16'hA000 | 16'(i);
      dut.rom[i] = rom_model[i];
    end

    Reset = 1'b1;
    Redirect = 1'b0;
    RedirectPC = '0;
    InstrReady = 1'b0;

    // Reset state
    step();
    step();
    @(negedge Clock);
    chk("rst_valid", InstrValid, 1'b0);
    chk("rst_instr", Instruction, 16'h0000);
    chk("rst_pc", InstrPC, 16'h0000);
    chk("rst_fault", InstrFault, 1'b0);
    chk("rst_fetchpc", FetchPC, 16'h0000);

    // First delivery latency and streaming throughput
    step();
    Reset = 1'b0;
    InstrReady = 1'b1;
    expect_seq(16'h0000, 4);
    @(negedge Clock); chk("lat_c0_valid", InstrValid, 1'b0);
    @(negedge Clock); chk("lat_c1_valid", InstrValid, 1'b0);
    @(negedge Clock); chk("lat_c2_valid", InstrValid, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      chk("stream_valid", InstrValid, 1'b1);
    end
    wait_drain("stream_drain");

    // Backpressure: queue fills, fetch stops, head holds
    Reset = 1'b1;
    InstrReady = 1'b0;
    step();
    step();
    Reset = 1'b0;
    repeat (8) step();
    @(negedge Clock);
    chk("full_valid", InstrValid, 1'b1);
    chk("full_pc", InstrPC, 16'h0000);
    chk("full_instr", Instruction, 16'h1111);
    chk("full_fetchpc", FetchPC, 16'h0008);
    for (int k = 0; k < 2; k++) begin
      @(negedge Clock);
      chk("hold_pc", InstrPC, 16'h0000);
      chk("hold_fetchpc", FetchPC, 16'h0008);
    end
    step();
    expect_seq(16'h0000, 5);
    InstrReady = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clock);
      chk("drain_nogap_valid", InstrValid, 1'b1);
    end
    wait_drain("drain_full");

    // Redirect table, each applied with a full queue
    for (int i = 0; i < 5; i++) begin
      step();
      InstrReady = 1'b0;
      repeat (6) step();
      Redirect = 1'b1;
      RedirectPC = vecs[i].target;
      InstrReady = vecs[i].rdy;
      step();
      Redirect = 1'b0;
      RedirectPC = '0;
      InstrReady = 1'b1;
      expect_seq(vecs[i].first_pc, vecs[i].n);
      @(negedge Clock);
      chk("redir_valid_low", InstrValid, 1'b0);
      chk("redir_fetchpc", FetchPC, vecs[i].first_pc);
      wait_drain("redir_drain");
    end

    // One-cycle reset with 3 queued and a read in flight
    Reset = 1'b1;
    InstrReady = 1'b0;
    step();
    step();
    Reset = 1'b0;
    repeat (4) step();
    Reset = 1'b1;
    @(negedge Clock);
    chk("midrst_pre_valid", InstrValid, 1'b1);
    chk("midrst_pre_fetchpc", FetchPC, 16'h0008);
    step();
    Reset = 1'b0;
    InstrReady = 1'b1;
    expect_seq(16'h0000, 3);
    @(negedge Clock);
    chk("midrst_valid", InstrValid, 1'b0);
    chk("midrst_fetchpc", FetchPC, 16'h0000);
    chk("midrst_pc", InstrPC, 16'h0000);
    @(negedge Clock);
    chk("midrst_c1_valid", InstrValid, 1'b0);
    @(negedge Clock);
    chk("midrst_c2_valid", InstrValid, 1'b1);
    wait_drain("midrst_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
